cc_posicion_driver: RTL and testbench

//  Source side of the position-display path: generates the one-hot location bus and the

---
 rtl/cc_posicion_driver.sv | 125 ++++++++++++
 tb/tb_cc_posicion_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cc_posicion_driver.sv
// Position source for the display path: tracks one player token on a row and drives its
// one-hot location plus the blank select, with a blink sequence when the token is hit.
module cc_posicion_driver #(
  parameter int unsigned POSDRV_WIDTH       = 8,
  parameter int unsigned POSDRV_START       = 3,
  parameter int unsigned POSDRV_BLINKCYCLES = 4,
  parameter int unsigned POSDRV_BLINKCOUNT  = 3
) (
  input  logic                    CC_POSDRV_CLOCK_50,
  input  logic                    CC_POSDRV_RESET_InLow,
  input  logic                    CC_POSDRV_start_In,
  input  logic                    CC_POSDRV_left_In,
  input  logic                    CC_POSDRV_right_In,
  input  logic                    CC_POSDRV_hit_In,
  output logic [POSDRV_WIDTH-1:0] CC_POSDRV_UBICACION_OutBUS,
  output logic                    CC_POSDRV_select_Out,
  output logic                    CC_POSDRV_busy_Out
);

  localparam int unsigned PosW = (POSDRV_WIDTH > 1) ? $clog2(POSDRV_WIDTH) : 1;
  localparam int unsigned CycW = $clog2(POSDRV_BLINKCYCLES) + 1;
  localparam int unsigned TogW = $clog2(2 * POSDRV_BLINKCOUNT) + 1;

  localparam logic [1:0] stIdle   = 2'd0;
  localparam logic [1:0] stActive = 2'd1;
  localparam logic [1:0] stHit    = 2'd2;

  localparam logic [PosW-1:0] startPos = PosW'(POSDRV_START);
  localparam logic [PosW-1:0] lastPos  = PosW'(POSDRV_WIDTH - 1);
  localparam logic [CycW-1:0] cycLast  = CycW'(POSDRV_BLINKCYCLES - 1);
  localparam logic [TogW-1:0] togLast  = TogW'(2 * POSDRV_BLINKCOUNT - 1);

  logic [1:0]      state, stateNext;
  logic [PosW-1:0] pos, posNext;
  logic [CycW-1:0] blinkCyc, cycNext;
  logic [TogW-1:0] blinkTog, togNext;
  logic            prevLeft, prevRight;
  logic            selectNext, busyNext;
  logic [POSDRV_WIDTH-1:0] ubicNext;
  logic            moveLeft, moveRight;

  assign moveLeft  = CC_POSDRV_left_In & ~prevLeft;
  assign moveRight = CC_POSDRV_right_In & ~prevRight;

  // State, position, blink counters and registered outputs
  always_ff @(posedge CC_POSDRV_CLOCK_50 or negedge CC_POSDRV_RESET_InLow) begin
    if (!CC_POSDRV_RESET_InLow) begin
      state                      <= stIdle;
      pos                        <= startPos;
      blinkCyc                   <= '0;
      blinkTog                   <= '0;
      prevLeft                   <= 1'b0;
      prevRight                  <= 1'b0;
      CC_POSDRV_UBICACION_OutBUS <= POSDRV_WIDTH'(1) << startPos;
      CC_POSDRV_select_Out       <= 1'b1;
      CC_POSDRV_busy_Out         <= 1'b0;
    end else begin
      state                      <= stateNext;
      pos                        <= posNext;
      blinkCyc                   <= cycNext;
      blinkTog                   <= togNext;
      prevLeft                   <= CC_POSDRV_left_In;
      prevRight                  <= CC_POSDRV_right_In;
      CC_POSDRV_UBICACION_OutBUS <= ubicNext;
      CC_POSDRV_select_Out       <= selectNext;
      CC_POSDRV_busy_Out         <= busyNext;
    end
  end

  // Next-state and next-output logic; hit outranks movement in ACTIVE
  always_comb begin
    stateNext  = state;
    posNext    = pos;
    cycNext    = blinkCyc;
    togNext    = blinkTog;
    selectNext = CC_POSDRV_select_Out;
    case (state)
      stIdle: begin
        selectNext = 1'b1;
        if (CC_POSDRV_start_In) begin
          stateNext  = stActive;
          posNext    = startPos;
          selectNext = 1'b0;
        end
      end
      stActive: begin
        selectNext = 1'b0;
        if (CC_POSDRV_hit_In) begin
          stateNext  = stHit;
          cycNext    = '0;
          togNext    = '0;
          selectNext = 1'b1;
        end else if (moveLeft && !moveRight) begin
          if (pos != '0) posNext = pos - PosW'(1);
        end else if (moveRight && !moveLeft) begin
          if (pos != lastPos) posNext = pos + PosW'(1);
        end
      end
      stHit: begin
        if (blinkCyc == cycLast) begin
          cycNext    = '0;
          togNext    = blinkTog + TogW'(1);
          selectNext = ~CC_POSDRV_select_Out;
          if (blinkTog == togLast) begin
            stateNext = stIdle;
            posNext   = startPos;
            togNext   = '0;
          end
        end else begin
          cycNext = blinkCyc + CycW'(1);
        end
      end
      default: begin
        stateNext  = stIdle;
        posNext    = startPos;
        cycNext    = '0;
        togNext    = '0;
        selectNext = 1'b1;
      end
    endcase
    busyNext = (stateNext != stIdle);
    ubicNext = POSDRV_WIDTH'(1) << posNext;
  end

endmodule

// File: tb/tb_cc_posicion_driver.sv
// Bench for cc_posicion_driver: a cycle-level behavioural model checked every cycle,
// plus literal expectations along a directed scenario.
module tb_cc_posicion_driver;

  localparam int W     = 8;
  localparam int START = 3;
  localparam int BCYC  = 4;
  localparam int BCNT  = 3;
  localparam int HITLEN = 2 * BCNT * BCYC;

  logic clk = 1'b0;
  logic rst_n;
  logic start, left, right, hit;
  logic [W-1:0] ubic;
  logic sel, busy;

  int checks = 0;
  int fails  = 0;

  cc_posicion_driver #(
    .POSDRV_WIDTH(W), .POSDRV_START(START),
    .POSDRV_BLINKCYCLES(BCYC), .POSDRV_BLINKCOUNT(BCNT)
  ) dut (
    .CC_POSDRV_CLOCK_50        (clk),
    .CC_POSDRV_RESET_InLow     (rst_n),
    .CC_POSDRV_start_In        (start),
    .CC_POSDRV_left_In         (left),
    .CC_POSDRV_right_In        (right),
    .CC_POSDRV_hit_In          (hit),
    .CC_POSDRV_UBICACION_OutBUS(ubic),
    .CC_POSDRV_select_Out      (sel),
    .CC_POSDRV_busy_Out        (busy)
  );

  always #5 clk = ~clk;

  // Model: mode 0=idle 1=active 2=hit; hitN counts edges since the hit was taken
  int mPos, mMode, hitN;
  bit mPrevL, mPrevR;

  always @(posedge clk or negedge rst_n) begin
    bit mvL, mvR;
    if (!rst_n) begin
      mPos = START; mMode = 0; hitN = 0; mPrevL = 0; mPrevR = 0;
    end else begin
      mvL = left && !mPrevL;
      mvR = right && !mPrevR;
      if (mMode == 0) begin
        if (start) begin mMode = 1; mPos = START; end
      end else if (mMode == 1) begin
        if (hit) begin mMode = 2; hitN = 0; end
        else if (mvL && !mvR) mPos = (mPos > 0) ? mPos - 1 : 0;
        else if (mvR && !mvL) mPos = (mPos < W - 1) ? mPos + 1 : W - 1;
      end else begin
        hitN++;
        if (hitN == HITLEN) begin mMode = 0; mPos = START; end
      end
      mPrevL = left;
      mPrevR = right;
    end
  end

  function automatic logic expSel();
    if (mMode == 0) return 1'b1;
    if (mMode == 1) return 1'b0;
    return ((hitN / BCYC) % 2) == 0;
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] eU;
    eU = W'(1) << mPos;
    checks++;
    if (ubic !== eU || sel !== expSel() || busy !== (mMode != 0)) begin
      fails++;
      $display("FAIL model t=%0t: ubic=%h sel=%b busy=%b, required ubic=%h sel=%b busy=%b",
               $time, ubic, sel, busy, eU, expSel(), mMode != 0);
    end
  end

  task automatic checkLit(input string name, input logic [W-1:0] eU, input logic eS, input logic eB);
    checks++;
    if (ubic !== eU || sel !== eS || busy !== eB) begin
      fails++;
      $display("FAIL %s: ubic=%h sel=%b busy=%b, required ubic=%h sel=%b busy=%b",
               name, ubic, sel, busy, eU, eS, eB);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseLeft(input int n);
    repeat (n) begin left = 1; step(1); left = 0; step(1); end
  endtask

  task automatic pulseRight(input int n);
    repeat (n) begin right = 1; step(1); right = 0; step(1); end
  endtask

  initial begin
    rst_n = 0; start = 0; left = 0; right = 0; hit = 0;
    // T1: inputs toggling under reset have no effect
    for (int i = 0; i < 4; i++) begin
      start = i[0]; left = i[1]; right = ~i[0]; hit = i[1];
      step(1);
    end
    checkLit("t1_reset", 8'h08, 1'b1, 1'b0);
    start = 0; left = 0; right = 0; hit = 0;
    step(1);
    rst_n = 1;
    step(1);
    checkLit("idle_after_reset", 8'h08, 1'b1, 1'b0);

    // Moves and hit ignored in IDLE
    pulseRight(1);
    hit = 1; step(1); hit = 0; step(1);
    checkLit("idle_ignores", 8'h08, 1'b1, 1'b0);

    // T2: start then two right pulses, one-cycle latency
    start = 1; step(1); start = 0;
    checkLit("t2_started", 8'h08, 1'b0, 1'b1);
    right = 1; step(1);
    checkLit("t2_right1", 8'h10, 1'b0, 1'b1);
    right = 0; step(1);
    right = 1; step(1);
    checkLit("t2_right2", 8'h20, 1'b0, 1'b1);
    right = 0; step(1);

    // T3: saturation at both ends
    pulseLeft(6);
    checkLit("t3_sat_low", 8'h01, 1'b0, 1'b1);
    pulseRight(9);
    checkLit("t3_sat_high", 8'h80, 1'b0, 1'b1);

    // T4: held left moves once; simultaneous edges cancel
    left = 1; step(10);
    checkLit("t4_held", 8'h40, 1'b0, 1'b1);
    left = 0; step(1);
    left = 1; right = 1; step(1);
    checkLit("t4_both", 8'h40, 1'b0, 1'b1);
    left = 0; right = 0; step(1);

    // T5: back to pos 3, hit with right edge in same cycle
    pulseLeft(3);
    checkLit("t5_pos3", 8'h08, 1'b0, 1'b1);
    hit = 1; right = 1; step(1);
    hit = 0; right = 0;
    checkLit("t5_hit_entry", 8'h08, 1'b1, 1'b1);
    start = 1; left = 1; step(BCYC);
    start = 0; left = 0;
    checkLit("t5_blink_off", 8'h08, 1'b0, 1'b1);
    step(HITLEN - BCYC - 1);
    checkLit("t5_last_hit_cycle", 8'h08, 1'b0, 1'b1);
    step(1);
    checkLit("t5_back_idle", 8'h08, 1'b1, 1'b0);

    // Button held across IDLE->ACTIVE does not move
    right = 1; step(2);
    start = 1; step(1); start = 0; step(2);
    checkLit("held_across_start", 8'h08, 1'b0, 1'b1);
    right = 0; step(1);
    pulseLeft(2);
    checkLit("pre_t6_pos1", 8'h02, 1'b0, 1'b1);

    // T6: asynchronous reset in the middle of HIT
    hit = 1; step(1); hit = 0;
    step(BCYC + 1);
    rst_n = 0;
    #1;
    checkLit("t6_async_reset", 8'h08, 1'b1, 1'b0);
    step(2);
    rst_n = 1;
    step(3);
    checkLit("t6_after_release", 8'h08, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
